// File: rtl/glb_strm_scheduler_if.sv
// Start/interrupt lanes between the stream scheduler (master) and global_buffer (slave).
interface glb_strm_scheduler_if #(
  parameter int unsigned NUM_GLB_TILES = 16
) ();
  logic [NUM_GLB_TILES-1:0] strm_start_pulse;
  logic [NUM_GLB_TILES-1:0] strm_g2f_interrupt_pulse;
  logic [NUM_GLB_TILES-1:0] strm_f2g_interrupt_pulse;

  modport master (
    output strm_start_pulse,
    input  strm_g2f_interrupt_pulse,
    input  strm_f2g_interrupt_pulse
  );

  modport slave (
    input  strm_start_pulse,
    output strm_g2f_interrupt_pulse,
    output strm_f2g_interrupt_pulse
  );
endinterface

// File: rtl/glb_strm_scheduler.sv
// Round-robin stream start scheduler for GLB tiles with a concurrency cap.
// Define GLB_SCHED_TIMEOUT_EN to add the per-tile run watchdog.
module glb_strm_scheduler #(
  parameter int unsigned NUM_GLB_TILES = 16,
  parameter int unsigned CNT_W         = 5,
  parameter int unsigned TIMEOUT_W     = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_GLB_TILES-1:0] start_req,
  input  logic [NUM_GLB_TILES-1:0] done_mask_g2f,
  input  logic [NUM_GLB_TILES-1:0] done_mask_f2g,
  input  logic [CNT_W-1:0]         max_active,
  input  logic [NUM_GLB_TILES-1:0] status_clr,
  glb_strm_scheduler_if.master     gb,
  output logic [NUM_GLB_TILES-1:0] tile_busy,
  output logic [CNT_W-1:0]         active_cnt,
  output logic [NUM_GLB_TILES-1:0] done_status,
  output logic [NUM_GLB_TILES-1:0] err_status,
`ifdef GLB_SCHED_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0]     timeout_cycles,
  output logic [NUM_GLB_TILES-1:0] timeout_status,
`endif
  output logic                     done_irq
);
  localparam int unsigned IdxW = (NUM_GLB_TILES > 1) ? $clog2(NUM_GLB_TILES) : 1;

  typedef enum logic [1:0] {StIdle, StPend, StRun} tile_st_e;

  tile_st_e                 st_q [NUM_GLB_TILES];
  logic [NUM_GLB_TILES-1:0] req_g2f_q, req_f2g_q, seen_g2f_q, seen_f2g_q;
  logic [NUM_GLB_TILES-1:0] start_pulse_q, done_status_q, err_status_q;
  logic [IdxW-1:0]          rr_q;
  logic [CNT_W-1:0]         active_cnt_q;
  logic                     done_irq_q;

  logic [NUM_GLB_TILES-1:0] pend_vec, run_vec, done_vec, to_vec, end_vec, err_vec, gnt_vec;
  logic                     gnt_vld, cap_ok;
  logic [IdxW-1:0]          gnt_idx;
  logic [CNT_W-1:0]         num_end;

  always_comb begin
    pend_vec = '0;
    run_vec  = '0;
    err_vec  = '0;
    done_vec = '0;
    for (int i = 0; i < NUM_GLB_TILES; i++) begin
      pend_vec[i] = (st_q[i] == StPend);
      run_vec[i]  = (st_q[i] == StRun);
      err_vec[i]  = start_req[i] && (st_q[i] != StIdle);
      // A pulse arriving this cycle counts toward completion at this edge.
      done_vec[i] = run_vec[i]
          && !(req_g2f_q[i] && !(seen_g2f_q[i] || gb.strm_g2f_interrupt_pulse[i]))
          && !(req_f2g_q[i] && !(seen_f2g_q[i] || gb.strm_f2g_interrupt_pulse[i]));
    end
  end

  // Round-robin pick starting at rr_q; the descending loop leaves the nearest hit.
  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] idx_t;
    idx     = 0;
    idx_t   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    cap_ok  = (max_active == '0) || (active_cnt_q < max_active);
    for (int unsigned k = NUM_GLB_TILES; k > 0; k--) begin
      idx   = (32'(rr_q) + k - 1) % NUM_GLB_TILES;
      idx_t = IdxW'(idx);
      if (cap_ok && pend_vec[idx_t]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_t;
      end
    end
    if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    end_vec = done_vec | to_vec;
    num_end = '0;
    for (int i = 0; i < NUM_GLB_TILES; i++) num_end = num_end + CNT_W'(end_vec[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GLB_TILES; i++) st_q[i] <= StIdle;
      req_g2f_q     <= '0;
      req_f2g_q     <= '0;
      seen_g2f_q    <= '0;
      seen_f2g_q    <= '0;
      start_pulse_q <= '0;
      done_status_q <= '0;
      err_status_q  <= '0;
      rr_q          <= '0;
      active_cnt_q  <= '0;
      done_irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GLB_TILES; i++) begin
        case (st_q[i])
          StIdle: if (start_req[i]) st_q[i] <= StPend;
          StPend: begin
            if (gnt_vec[i]) begin
              st_q[i]       <= StRun;
              req_g2f_q[i]  <= done_mask_g2f[i];
              req_f2g_q[i]  <= done_mask_f2g[i];
              seen_g2f_q[i] <= 1'b0;
              seen_f2g_q[i] <= 1'b0;
            end
          end
          StRun: begin
            if (end_vec[i]) begin
              st_q[i] <= StIdle;
            end else begin
              seen_g2f_q[i] <= seen_g2f_q[i] | gb.strm_g2f_interrupt_pulse[i];
              seen_f2g_q[i] <= seen_f2g_q[i] | gb.strm_f2g_interrupt_pulse[i];
            end
          end
          default: st_q[i] <= StIdle;
        endcase
      end
      start_pulse_q <= gnt_vec;
      done_irq_q    <= |end_vec;
      done_status_q <= (done_status_q & ~status_clr) | done_vec;
      err_status_q  <= (err_status_q & ~status_clr) | err_vec;
      active_cnt_q  <= active_cnt_q + CNT_W'(gnt_vld) - num_end;
      if (gnt_vld) rr_q <= IdxW'((32'(gnt_idx) + 1) % NUM_GLB_TILES);
    end
  end

`ifdef GLB_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]     to_cnt_q [NUM_GLB_TILES];
  logic [NUM_GLB_TILES-1:0] timeout_status_q;

  // Done takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    to_vec = '0;
    for (int i = 0; i < NUM_GLB_TILES; i++) begin
      to_vec[i] = run_vec[i] && !done_vec[i] && (timeout_cycles != '0)
                  && (to_cnt_q[i] == timeout_cycles);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GLB_TILES; i++) to_cnt_q[i] <= '0;
      timeout_status_q <= '0;
    end else begin
      for (int i = 0; i < NUM_GLB_TILES; i++) begin
        if (gnt_vec[i]) begin
          to_cnt_q[i] <= '0;
        end else if (run_vec[i] && (to_cnt_q[i] != {TIMEOUT_W{1'b1}})) begin
          to_cnt_q[i] <= to_cnt_q[i] + 1'b1;
        end
      end
      timeout_status_q <= (timeout_status_q & ~status_clr) | to_vec;
    end
  end

  assign timeout_status = timeout_status_q;
`else
  assign to_vec = '0;
`endif

  assign gb.strm_start_pulse = start_pulse_q;
  assign tile_busy           = pend_vec | run_vec;
  assign active_cnt          = active_cnt_q;
  assign done_status         = done_status_q;
  assign err_status          = err_status_q;
  assign done_irq            = done_irq_q;
endmodule

// File: tb/tb_glb_strm_scheduler.sv
// Directed self-checking bench for glb_strm_scheduler; the watchdog scenario runs only
// when GLB_SCHED_TIMEOUT_EN is defined.
module tb_glb_strm_scheduler;
  logic        clk;
  logic        reset;
  logic [15:0] start_req, done_mask_g2f, done_mask_f2g, status_clr;
  logic [4:0]  max_active;
  logic [15:0] tile_busy, done_status, err_status;
  logic [4:0]  active_cnt;
  logic        done_irq;
`ifdef GLB_SCHED_TIMEOUT_EN
  logic [23:0] timeout_cycles;
  logic [15:0] timeout_status;
`endif
  int errors;
  int checks;

  glb_strm_scheduler_if #(.NUM_GLB_TILES(16)) gb_if ();

  glb_strm_scheduler #(
    .NUM_GLB_TILES(16),
    .CNT_W        (5),
    .TIMEOUT_W    (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_req    (start_req),
    .done_mask_g2f(done_mask_g2f),
    .done_mask_f2g(done_mask_f2g),
    .max_active   (max_active),
    .status_clr   (status_clr),
    .gb           (gb_if),
    .tile_busy    (tile_busy),
    .active_cnt   (active_cnt),
    .done_status  (done_status),
    .err_status   (err_status),
`ifdef GLB_SCHED_TIMEOUT_EN
    .timeout_cycles(timeout_cycles),
    .timeout_status(timeout_status),
`endif
    .done_irq     (done_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic g2f(input logic [15:0] v);
    gb_if.strm_g2f_interrupt_pulse = v;
    step();
    gb_if.strm_g2f_interrupt_pulse = '0;
  endtask

  task automatic f2g(input logic [15:0] v);
    gb_if.strm_f2g_interrupt_pulse = v;
    step();
    gb_if.strm_f2g_interrupt_pulse = '0;
  endtask

  task automatic clear_all();
    status_clr = 16'hFFFF;
    step();
    status_clr = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (gb_if.strm_start_pulse !== 16'h0) begin errors++;
      $display("FAIL reset_pulse: got %h exp 0000", gb_if.strm_start_pulse); end
    checks++; if (tile_busy !== 16'h0 || active_cnt !== 5'd0) begin errors++;
      $display("FAIL reset_busy_cnt: got %h/%0d exp 0000/0", tile_busy, active_cnt); end
    checks++; if (done_status !== 16'h0 || err_status !== 16'h0 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %h/%h/%b exp 0/0/0", done_status, err_status, done_irq);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    done_mask_g2f = 16'h0008; done_mask_f2g = 16'h0; max_active = 5'd0;
    start_req = 16'h0008;
    step();
    start_req = '0;
    checks++; if (tile_busy !== 16'h0008 || gb_if.strm_start_pulse !== 16'h0) begin errors++;
      $display("FAIL single_pend: got %h/%h exp 0008/0000", tile_busy, gb_if.strm_start_pulse); end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0008 || active_cnt !== 5'd1) begin errors++;
      $display("FAIL single_grant: got %h/%0d exp 0008/1", gb_if.strm_start_pulse, active_cnt); end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0) begin errors++;
      $display("FAIL single_pulse_width: got %h exp 0000", gb_if.strm_start_pulse); end
    g2f(16'h0008);
    checks++; if (done_status !== 16'h0008 || done_irq !== 1'b1 || active_cnt !== 5'd0) begin
      errors++;
      $display("FAIL single_done: got %h/%b/%0d exp 0008/1/0", done_status, done_irq, active_cnt);
    end
    step();
    checks++; if (done_irq !== 1'b0 || tile_busy !== 16'h0) begin errors++;
      $display("FAIL single_irq_width: got %b/%h exp 0/0000", done_irq, tile_busy); end
    clear_all();
    checks++; if (done_status !== 16'h0) begin errors++;
      $display("FAIL single_clr: got %h exp 0000", done_status); end
  endtask

  task automatic test_cap();
    done_mask_g2f = 16'h000F; max_active = 5'd2;
    start_req = 16'h000F;
    step();
    start_req = '0;
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0001 || active_cnt !== 5'd1) begin errors++;
      $display("FAIL cap_g0: got %h/%0d exp 0001/1", gb_if.strm_start_pulse, active_cnt); end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0002 || active_cnt !== 5'd2) begin errors++;
      $display("FAIL cap_g1: got %h/%0d exp 0002/2", gb_if.strm_start_pulse, active_cnt); end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0 || active_cnt !== 5'd2) begin errors++;
      $display("FAIL cap_stall: got %h/%0d exp 0000/2", gb_if.strm_start_pulse, active_cnt); end
    g2f(16'h0001);
    checks++; if (gb_if.strm_start_pulse !== 16'h0 || active_cnt !== 5'd1) begin errors++;
      $display("FAIL cap_free_next: got %h/%0d exp 0000/1", gb_if.strm_start_pulse, active_cnt); end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0004 || active_cnt !== 5'd2) begin errors++;
      $display("FAIL cap_g2: got %h/%0d exp 0004/2", gb_if.strm_start_pulse, active_cnt); end
    g2f(16'h0006);
    checks++; if (done_status !== 16'h0007 || done_irq !== 1'b1 || active_cnt !== 5'd0) begin
      errors++;
      $display("FAIL cap_multi_done: got %h/%b/%0d exp 0007/1/0", done_status, done_irq,
               active_cnt);
    end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0008 || done_irq !== 1'b0) begin errors++;
      $display("FAIL cap_g3: got %h/%b exp 0008/0", gb_if.strm_start_pulse, done_irq); end
    g2f(16'h0008);
    clear_all();
  endtask

  task automatic test_round_robin();
    logic [15:0] grants[$];
    logic [15:0] exp_seq [6];
    exp_seq = '{16'h0020, 16'h0001, 16'h0020, 16'h0001, 16'h0020, 16'h0001};
    done_mask_g2f = '0; done_mask_f2g = '0; max_active = 5'd1;
    start_req = 16'h0021;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gb_if.strm_start_pulse != 16'h0) grants.push_back(gb_if.strm_start_pulse);
      start_req  = done_status & 16'h0021;
      status_clr = done_status;
    end
    start_req = '0; status_clr = '0;
    checks++; if (grants.size() < 6) begin errors++;
      $display("FAIL rr_count: got %0d exp >=6", grants.size()); end
    for (int g = 0; g < 6 && g < grants.size(); g++) begin
      checks++; if (grants[g] !== exp_seq[g]) begin errors++;
        $display("FAIL rr_order[%0d]: got %h exp %h", g, grants[g], exp_seq[g]); end
    end
    repeat (6) step();
    checks++; if (tile_busy !== 16'h0 || active_cnt !== 5'd0) begin errors++;
      $display("FAIL rr_drain: got %h/%0d exp 0000/0", tile_busy, active_cnt); end
    clear_all();
  endtask

  task automatic test_both_masks_err();
    done_mask_g2f = 16'h0002; done_mask_f2g = 16'h0002; max_active = 5'd0;
    start_req = 16'h0002;
    step();
    start_req = '0;
    f2g(16'h0002);  // lands on the grant edge, must not count
    checks++; if (gb_if.strm_start_pulse !== 16'h0002) begin errors++;
      $display("FAIL both_grant: got %h exp 0002", gb_if.strm_start_pulse); end
    done_mask_g2f = '0; done_mask_f2g = '0;
    g2f(16'h0002);
    repeat (9) step();
    checks++; if (tile_busy !== 16'h0002 || done_status !== 16'h0) begin errors++;
      $display("FAIL both_wait: got %h/%h exp 0002/0000", tile_busy, done_status); end
    start_req = 16'h0002;
    step();
    start_req = '0;
    checks++; if (err_status !== 16'h0002 || gb_if.strm_start_pulse !== 16'h0) begin errors++;
      $display("FAIL both_err: got %h/%h exp 0002/0000", err_status, gb_if.strm_start_pulse); end
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0 || active_cnt !== 5'd1) begin errors++;
      $display("FAIL both_no_requeue: got %h/%0d exp 0000/1", gb_if.strm_start_pulse,
               active_cnt); end
    f2g(16'h0002);
    checks++; if (done_status !== 16'h0002 || tile_busy !== 16'h0 || done_irq !== 1'b1) begin
      errors++;
      $display("FAIL both_done: got %h/%h/%b exp 0002/0000/1", done_status, tile_busy, done_irq);
    end
    clear_all();
    checks++; if (err_status !== 16'h0) begin errors++;
      $display("FAIL both_err_clr: got %h exp 0000", err_status); end
  endtask

  task automatic test_set_wins();
    start_req = 16'h0080;
    step();
    start_req = '0;
    step();
    status_clr = 16'h0080;
    step();
    checks++; if (done_status !== 16'h0080 || done_irq !== 1'b1) begin errors++;
      $display("FAIL setwin_done: got %h/%b exp 0080/1", done_status, done_irq); end
    step();
    status_clr = '0;
    checks++; if (done_status !== 16'h0) begin errors++;
      $display("FAIL setwin_clr: got %h exp 0000", done_status); end
  endtask

  task automatic test_lower_cap();
    done_mask_g2f = 16'h0F00; max_active = 5'd0;
    start_req = 16'h0700;
    step();
    start_req = '0;
    repeat (3) step();
    checks++; if (active_cnt !== 5'd3) begin errors++;
      $display("FAIL lcap_three: got %0d exp 3", active_cnt); end
    max_active = 5'd2; start_req = 16'h0800;
    step();
    start_req = '0;
    step();
    g2f(16'h0100);
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0 || active_cnt !== 5'd2) begin errors++;
      $display("FAIL lcap_hold: got %h/%0d exp 0000/2", gb_if.strm_start_pulse, active_cnt); end
    g2f(16'h0200);
    step();
    checks++; if (gb_if.strm_start_pulse !== 16'h0800 || active_cnt !== 5'd2) begin errors++;
      $display("FAIL lcap_grant: got %h/%0d exp 0800/2", gb_if.strm_start_pulse, active_cnt); end
    g2f(16'h0C00);
    checks++; if (active_cnt !== 5'd0) begin errors++;
      $display("FAIL lcap_drain: got %0d exp 0", active_cnt); end
    clear_all();
    max_active = 5'd0;
  endtask

  task automatic test_reset_midrun();
    done_mask_g2f = 16'h0007; max_active = 5'd2;
    start_req = 16'h0007;
    step();
    start_req = '0;
    step();
    step();
    start_req = 16'h0001;
    step();
    start_req = '0;
    #3 reset = 1'b0;
    #1;
    checks++; if (tile_busy !== 16'h0 || active_cnt !== 5'd0 || err_status !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: got %h/%0d/%h exp 0000/0/0000", tile_busy, active_cnt, err_status);
    end
    step();
    #3 reset = 1'b1;
    step();
    gb_if.strm_f2g_interrupt_pulse = 16'h0007;
    g2f(16'h0007);
    gb_if.strm_f2g_interrupt_pulse = '0;
    step();
    checks++; if (done_status !== 16'h0 || done_irq !== 1'b0 || tile_busy !== 16'h0 ||
                  gb_if.strm_start_pulse !== 16'h0) begin errors++;
      $display("FAIL rst_stale: got %h/%b/%h/%h exp 0/0/0/0", done_status, done_irq, tile_busy,
               gb_if.strm_start_pulse); end
    max_active = 5'd0;
  endtask

`ifdef GLB_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    k = 0;
    done_mask_g2f = 16'h0001; timeout_cycles = 24'd100;
    start_req = 16'h0001;
    step();
    start_req = '0;
    step();
    while (k < 130 && timeout_status[0] !== 1'b1) begin
      step();
      k++;
    end
    checks++; if (k != 101) begin errors++;
      $display("FAIL to_latency: got %0d exp 101", k); end
    checks++; if (done_status !== 16'h0 || active_cnt !== 5'd0 || done_irq !== 1'b1) begin
      errors++;
      $display("FAIL to_state: got %h/%0d/%b exp 0000/0/1", done_status, active_cnt, done_irq);
    end
    timeout_cycles = '0;
    clear_all();
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0;
    start_req = '0; done_mask_g2f = '0; done_mask_f2g = '0; status_clr = '0; max_active = '0;
    gb_if.strm_g2f_interrupt_pulse = '0;
    gb_if.strm_f2g_interrupt_pulse = '0;
`ifdef GLB_SCHED_TIMEOUT_EN
    timeout_cycles = '0;
`endif
    test_reset();
    test_single();
    test_cap();
    test_round_robin();
    test_both_masks_err();
    test_set_wins();
    test_lower_cap();
    test_reset_midrun();
`ifdef GLB_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
